// File: rtl/mul_out_pkg.sv
// ============================================================================
// Package : mul_out_pkg
// Shared lane/exponent widths and the collector state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DW
`define DW 16
`endif

package mul_out_pkg;

  localparam int LANES = 4;
  localparam int EXP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_EXP_REQ  = 2'd2,
    ST_EXP_WAIT = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mul_out_collector_sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Single-clock FIFO with show-ahead read data; push is accepted when full
// only if a pop happens in the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic             w_wr;
  logic             w_rd;

  assign full    = (r_count == c_CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_rd    = rd_en && !empty;
  assign w_wr    = wr_en && (!full || w_rd);
  assign rd_data = r_mem[r_rd_ptr];

  // Storage is left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_out_collector.sv
// ============================================================================
// Module  : mul_out_collector
// Buffers 4-lane product words, serializes them lane by lane and runs the
// per-batch exponent handshake (compiled only with COLLECT_EXP_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DW
`define DW 16
`endif

module mul_out_collector
  import mul_out_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [10:0]           batch_len_minusone,
  input  logic                  start,
  input  logic [LANES*`DW-1:0]  in_data,
  input  logic                  in_vld,
  output logic [`DW-1:0]        out_data,
  output logic                  out_vld,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  max_exponent_ready,
  input  logic [EXP_W-1:0]      max_exponent,
  input  logic                  max_exponent_vld,
  output logic [EXP_W-1:0]      exp_out,
  output logic                  exp_out_vld,
  output logic                  ovf_err,
  output logic                  seq_err
);

  localparam int c_WW = LANES * `DW;
  localparam int c_LW = $clog2(LANES);
  localparam logic [c_LW-1:0] c_LAST_LANE = c_LW'(LANES - 1);

  state_t            r_state;
  logic [10:0]       r_len;
  logic [10:0]       r_cnt;
  logic [c_LW-1:0]   r_lane;
  logic [`DW-1:0]    r_out_data;
  logic              r_out_vld;
  logic              r_out_last;
  logic              r_ovf;

  logic [c_WW:0]     w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_load;
  logic              w_pop;
  logic              w_push_req;
  logic              w_push_ok;
  logic              w_last_tag;
  logic              w_batch_done;

  assign w_push_req   = in_vld && (r_state != ST_IDLE);
  // A lane is staged whenever the output register is free or draining.
  assign w_load       = !w_empty && (!r_out_vld || out_ready);
  assign w_pop        = w_load && (r_lane == c_LAST_LANE);
  assign w_push_ok    = w_push_req && (!w_full || w_pop);
  assign w_last_tag   = (r_cnt == r_len);
  assign w_batch_done = w_push_ok && w_last_tag;

  sync_fifo #(
    .WIDTH (c_WW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push_ok),
    .wr_data ({w_last_tag, in_data}),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Serializer: the word stays at the FIFO head until its last lane is staged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_lane     <= '0;
    end else if (w_load) begin
      r_out_data <= w_head[r_lane*`DW +: `DW];
      r_out_last <= w_head[c_WW] && (r_lane == c_LAST_LANE);
      r_out_vld  <= 1'b1;
      r_lane     <= r_lane + 1'b1;
    end else if (out_ready) begin
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_len <= batch_len_minusone;
        r_cnt <= '0;
      end else if (w_push_ok) begin
        r_cnt <= w_last_tag ? 11'd0 : (r_cnt + 11'd1);
      end
      if (w_push_req && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

`ifdef COLLECT_EXP_EN
  logic              r_exp_ready;
  logic [EXP_W-1:0]  r_exp_out;
  logic              r_exp_vld;
  logic              r_seq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_exp_ready <= 1'b0;
      r_exp_out   <= '0;
      r_exp_vld   <= 1'b0;
      r_seq       <= 1'b0;
    end else begin
      r_exp_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (w_batch_done) begin
            r_state     <= ST_EXP_REQ;
            r_exp_ready <= 1'b1;
          end
        end
        ST_EXP_REQ: begin
          r_exp_ready <= 1'b0;
          r_state     <= ST_EXP_WAIT;
          if (w_batch_done) begin
            r_seq <= 1'b1;
          end
        end
        ST_EXP_WAIT: begin
          // A batch closing before the exponent returns is kept but flagged.
          if (w_batch_done) begin
            r_seq <= 1'b1;
          end
          if (max_exponent_vld) begin
            r_exp_out <= max_exponent;
            r_exp_vld <= 1'b1;
            r_state   <= ST_COLLECT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign max_exponent_ready = r_exp_ready;
  assign exp_out            = r_exp_out;
  assign exp_out_vld        = r_exp_vld;
  assign seq_err            = r_seq;
`else
  logic w_unused;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if ((r_state == ST_IDLE) && start) begin
      r_state <= ST_COLLECT;
    end
  end

  assign w_unused           = ^{max_exponent, max_exponent_vld, w_batch_done};
  assign max_exponent_ready = 1'b0;
  assign exp_out            = '0;
  assign exp_out_vld        = 1'b0;
  assign seq_err            = 1'b0;
`endif

  assign out_data = r_out_data;
  assign out_vld  = r_out_vld;
  assign out_last = r_out_last;
  assign ovf_err  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mul_out_collector.sv
// ============================================================================
// Module  : tb_mul_out_collector
// Self-checking bench: lane scoreboard plus directed and random scenarios.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DW
`define DW 16
`endif

module tb_mul_out_collector;

  localparam int DW = `DW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [10:0]     batch_len_minusone = '0;
  logic            start = 1'b0;
  logic [4*DW-1:0] in_data = '0;
  logic            in_vld = 1'b0;
  logic [DW-1:0]   out_data;
  logic            out_vld;
  logic            out_ready = 1'b0;
  logic            out_last;
  logic            max_exponent_ready;
  logic [7:0]      max_exponent = '0;
  logic            max_exponent_vld = 1'b0;
  logic [7:0]      exp_out;
  logic            exp_out_vld;
  logic            ovf_err;
  logic            seq_err;

  mul_out_collector #(.FIFO_DEPTH(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .batch_len_minusone (batch_len_minusone),
    .start              (start),
    .in_data            (in_data),
    .in_vld             (in_vld),
    .out_data           (out_data),
    .out_vld            (out_vld),
    .out_ready          (out_ready),
    .out_last           (out_last),
    .max_exponent_ready (max_exponent_ready),
    .max_exponent       (max_exponent),
    .max_exponent_vld   (max_exponent_vld),
    .exp_out            (exp_out),
    .exp_out_vld        (exp_out_vld),
    .ovf_err            (ovf_err),
    .seq_err            (seq_err)
  );

  always #5 clk = ~clk;

`ifdef COLLECT_EXP_EN
  localparam bit EXP_EN = 1'b1;
`else
  localparam bit EXP_EN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Expected lanes in delivery order: {last, data}.
  logic [DW:0] exp_q [$];
  int          tb_len = 0;
  int          tb_cnt = 0;

  // out_ready policy: 0 = hold ready_level, 1 = toggle, 2 = random.
  int   ready_mode  = 0;
  logic ready_level = 1'b0;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = ready_level;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  int          mer_cycles = 0;
  int          expvld_cycles = 0;
  int          xfer_count = 0;
  logic        stalled = 1'b0;
  logic [DW-1:0] held_data = '0;
  logic        held_last = 1'b0;
  logic [DW:0] mon_e;

  always @(negedge clk) begin
    if (stalled) begin
      checks++;
      if (out_vld !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
        errors++;
        $display("FAIL stall_hold got vld=%b data=%h last=%b want vld=1 data=%h last=%b",
                 out_vld, out_data, out_last, held_data, held_last);
      end
    end
    if (!rst && out_vld === 1'b1 && out_ready === 1'b1) begin
      checks++;
      xfer_count++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL lane_extra got data=%h last=%b want none", out_data, out_last);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_last, out_data} !== mon_e) begin
          errors++;
          $display("FAIL lane got last=%b data=%h want last=%b data=%h",
                   out_last, out_data, mon_e[DW], mon_e[DW-1:0]);
        end
      end
    end
    stalled   = !rst && (out_vld === 1'b1) && (out_ready === 1'b0);
    held_data = out_data;
    held_last = out_last;
    if (max_exponent_ready === 1'b1) mer_cycles++;
    if (exp_out_vld === 1'b1) expvld_cycles++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [4*DW-1:0] rand_word();
    logic [4*DW-1:0] w;
    for (int l = 0; l < 4; l++) w[l*DW +: DW] = DW'($urandom);
    return w;
  endfunction

  // Reference: word k of a batch closes it when k equals the batch length minus one.
  task automatic push_model(input logic [4*DW-1:0] w);
    bit last;
    last = (tb_cnt == tb_len);
    for (int l = 0; l < 4; l++) exp_q.push_back({last && (l == 3), w[l*DW +: DW]});
    tb_cnt = last ? 0 : tb_cnt + 1;
  endtask

  task automatic send_word(input logic [4*DW-1:0] w, input bit accepted);
    in_vld  = 1'b1;
    in_data = w;
    if (accepted) push_model(w);
    tick();
    in_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    tb_cnt = 0;
  endtask

  task automatic start_batch(input int len);
    batch_len_minusone = 11'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    tb_len = len;
    tb_cnt = 0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000 && (exp_q.size() != 0 || out_vld === 1'b1); i++) tick();
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d lanes outstanding want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Called right after the word that closes a batch; the request must be up now.
  task automatic exp_respond(input string name, input logic [7:0] v);
    int e0;
    e0 = expvld_cycles;
    checks++;
    if (max_exponent_ready !== EXP_EN) begin
      errors++;
      $display("FAIL %s_req got %b want %b", name, max_exponent_ready, EXP_EN);
    end
    if (EXP_EN) begin
      max_exponent_vld = 1'b1;
      max_exponent     = ~v;
      tick();
      max_exponent     = v;
      tick();
      max_exponent_vld = 1'b0;
      checks++;
      if (exp_out !== v || exp_out_vld !== 1'b1) begin
        errors++;
        $display("FAIL %s_exp got exp=%h vld=%b want exp=%h vld=1", name, exp_out, exp_out_vld, v);
      end
      tick();
      checks++;
      if (exp_out_vld !== 1'b0 || expvld_cycles - e0 != 1) begin
        errors++;
        $display("FAIL %s_exp_pulse got vld=%b pulses=%0d want 0 and 1",
                 name, exp_out_vld, expvld_cycles - e0);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    checks++;
    if (out_vld !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || max_exponent_ready !== 1'b0 ||
        exp_out_vld !== 1'b0 || exp_out !== 8'h00 || ovf_err !== 1'b0 || seq_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got vld=%b last=%b data=%h req=%b ev=%b exp=%h ovf=%b seq=%b want all 0",
               out_vld, out_last, out_data, max_exponent_ready, exp_out_vld, exp_out, ovf_err, seq_err);
    end
  endtask

  task automatic test_basic(input string name);
    logic [4*DW-1:0] w;
    int m0, x0;
    ready_mode  = 0;
    ready_level = 1'b1;
    tick();
    m0 = mer_cycles;
    x0 = xfer_count;
    start_batch(3);
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < 4; l++) w[l*DW +: DW] = DW'(4 * k + l + 1);
      in_vld  = 1'b1;
      in_data = w;
      push_model(w);
      tick();
      if (k == 0) begin
        checks++;
        if (out_vld !== 1'b0) begin
          errors++;
          $display("FAIL %s_lat_early got vld=%b want 0", name, out_vld);
        end
      end
      if (k == 1) begin
        checks++;
        if (out_vld !== 1'b1 || out_data !== DW'(1)) begin
          errors++;
          $display("FAIL %s_lat_lane0 got vld=%b data=%h want vld=1 data=1", name, out_vld, out_data);
        end
      end
    end
    in_vld = 1'b0;
    exp_respond(name, 8'h85);
    drain(name);
    checks++;
    if (mer_cycles - m0 != (EXP_EN ? 1 : 0) || xfer_count - x0 != 16) begin
      errors++;
      $display("FAIL %s_counts got req_cycles=%0d lanes=%0d want %0d and 16",
               name, mer_cycles - m0, xfer_count - x0, EXP_EN ? 1 : 0);
    end
  endtask

  task automatic test_overflow();
    ready_mode  = 0;
    ready_level = 1'b0;
    do_reset();
    start_batch(31);
    for (int k = 0; k < 16; k++) send_word(rand_word(), 1'b1);
    tick(4);
    checks++;
    if (ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full got ovf=%b want 0", ovf_err);
    end
    send_word(rand_word(), 1'b0);
    checks++;
    if (ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop got ovf=%b want 1", ovf_err);
    end
    ready_level = 1'b1;
    drain("ovf");
  endtask

  task automatic test_back_to_back();
    int x0;
    ready_mode = 1;
    do_reset();
    x0 = xfer_count;
    start_batch(7);
    for (int k = 0; k < 8; k++) begin
      send_word(rand_word(), 1'b1);
      if (k != 7) tick(2);
    end
    exp_respond("toggle", 8'($urandom));
    drain("toggle");
    checks++;
    if (xfer_count - x0 != 32) begin
      errors++;
      $display("FAIL toggle_count got %0d lanes want 32", xfer_count - x0);
    end
  endtask

  task automatic test_seq_err();
    int m0;
    ready_mode  = 0;
    ready_level = 1'b1;
    do_reset();
    m0 = mer_cycles;
    start_batch(0);
    send_word(rand_word(), 1'b1);
    checks++;
    if (max_exponent_ready !== EXP_EN) begin
      errors++;
      $display("FAIL seq_req got %b want %b", max_exponent_ready, EXP_EN);
    end
    send_word(rand_word(), 1'b1);
    tick(4);
    checks++;
    if (seq_err !== EXP_EN || mer_cycles - m0 != (EXP_EN ? 1 : 0)) begin
      errors++;
      $display("FAIL seq_err got seq=%b req_cycles=%0d want %b and %0d",
               seq_err, mer_cycles - m0, EXP_EN, EXP_EN ? 1 : 0);
    end
    drain("seq");
  endtask

  task automatic test_reset_mid();
    ready_mode  = 0;
    ready_level = 1'b0;
    do_reset();
    start_batch(3);
    send_word(rand_word(), 1'b1);
    send_word(rand_word(), 1'b1);
    tick(2);
    rst = 1'b1;
    tick();
    checks++;
    if (out_vld !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || max_exponent_ready !== 1'b0 ||
        exp_out_vld !== 1'b0 || exp_out !== 8'h00 || ovf_err !== 1'b0 || seq_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state got vld=%b last=%b data=%h req=%b ev=%b exp=%h ovf=%b seq=%b want all 0",
               out_vld, out_last, out_data, max_exponent_ready, exp_out_vld, exp_out, ovf_err, seq_err);
    end
    rst = 1'b0;
    exp_q.delete();
    tb_cnt = 0;
    ready_level = 1'b1;
    tick(4);
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL midrst_empty got vld=%b want 0", out_vld);
    end
    test_basic("after_rst");
  endtask

  task automatic test_random();
    int len;
    ready_mode = 2;
    do_reset();
    len = $urandom_range(0, 5);
    start_batch(len);
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k <= len; k++) begin
        send_word(rand_word(), 1'b1);
        if (k == len) exp_respond("rand", 8'($urandom));
        tick($urandom_range(6, 9));
      end
    end
    drain("rand");
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_overflow();
    test_back_to_back();
    test_seq_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
